// File: rtl/led_event_blinker_if.sv
// Event/clear request side and LED/status side of the event blinker.
// The master drives evt/clear; the slave (blinker) returns registered status.
interface led_event_blinker_if #(
  parameter int PW = 4
);
  logic          evt;
  logic          clear;
  logic          led;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  modport master (
    output evt, clear,
    input  led, busy, pending, overflow
  );

  modport slave (
    input  evt, clear,
    output led, busy, pending, overflow
  );
endinterface

// File: rtl/led_event_blinker.sv
// Stretches single-cycle events into ON_TIME-high / OFF_TIME-low LED blinks, one cycle after the event.
// No backpressure: extra events queue in a saturating counter; losses set sticky overflow.
module led_event_blinker #(
  parameter int ON_TIME  = 25000000,
  parameter int OFF_TIME = 25000000,
  parameter int CW       = 25,
  parameter int MAX_PEND = 15,
  parameter int PW       = 4
) (
  input logic                 clk,
  input logic                 reset,
  led_event_blinker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_TIME - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_TIME - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);

  state_t        state, state_n;
  logic [CW-1:0] timer, timer_n;
  logic [PW-1:0] pend_q, pend_n;
  logic          ovf_q, ovf_n;
  logic          led_q, busy_q;
  logic          inc, dec;

  always_comb begin
    state_n = state;
    timer_n = timer;
    pend_n  = pend_q;
    ovf_n   = ovf_q;
    inc     = 1'b0;
    dec     = 1'b0;
    if (bus.clear) begin
      state_n = IDLE;
      timer_n = '0;
      pend_n  = '0;
      ovf_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // The starting event is the blink itself, never queued.
          if (bus.evt) begin
            state_n = ON;
            timer_n = ON_LOAD;
          end
        end
        ON: begin
          inc = bus.evt;
          if (timer == '0) begin
            state_n = OFF;
            timer_n = OFF_LOAD;
          end else begin
            timer_n = timer - CW'(1);
          end
        end
        OFF: begin
          inc = bus.evt;
          if (timer == '0) begin
            if (pend_q != '0) begin
              state_n = ON;
              timer_n = ON_LOAD;
              dec     = 1'b1;
            end else if (bus.evt) begin
              // Empty queue: a same-cycle event starts the next blink directly.
              state_n = ON;
              timer_n = ON_LOAD;
              inc     = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            timer_n = timer - CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          timer_n = '0;
        end
      endcase

      if (inc && !dec) begin
        if (pend_q == PEND_MAX) begin
          ovf_n = 1'b1;
        end else begin
          pend_n = pend_q + PW'(1);
        end
      end else if (dec && !inc) begin
        pend_n = pend_q - PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      timer  <= '0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
      led_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      pend_q <= pend_n;
      ovf_q  <= ovf_n;
      led_q  <= (state_n == ON);
      busy_q <= (state_n != IDLE);
    end
  end

  assign bus.led      = led_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;

endmodule
